// File: rtl/id_ex_alu_ctrl_pkg.sv
// Shared decode constants and the control bundle passed from the ID decoder
// to the ID/EX register.
package id_ex_alu_ctrl_pkg;

    localparam int IWIDTH    = 32;
    localparam int PC_WIDTH  = 32;
    localparam int IMM_WIDTH = 16;
    localparam int FUNCT_W   = 5;
    localparam int DWIDTH    = 32;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD  = 5'd0;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB  = 5'd1;
    localparam logic [FUNCT_W-1:0] FUNCT_AND  = 5'd2;
    localparam logic [FUNCT_W-1:0] FUNCT_OR   = 5'd3;
    localparam logic [FUNCT_W-1:0] FUNCT_XOR  = 5'd4;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT  = 5'd5;
    localparam logic [FUNCT_W-1:0] FUNCT_SLTU = 5'd6;
    localparam logic [FUNCT_W-1:0] FUNCT_SLL  = 5'd7;
    localparam logic [FUNCT_W-1:0] FUNCT_SRL  = 5'd8;
    localparam logic [FUNCT_W-1:0] FUNCT_SRA  = 5'd9;
    localparam logic [FUNCT_W-1:0] FUNCT_EQ   = 5'd10;
    localparam logic [FUNCT_W-1:0] FUNCT_NEQ  = 5'd11;
    localparam logic [FUNCT_W-1:0] FUNCT_GE   = 5'd12;
    localparam logic [FUNCT_W-1:0] FUNCT_GEU  = 5'd13;
    localparam logic [FUNCT_W-1:0] FUNCT_ADDU = 5'd14;
    localparam logic [FUNCT_W-1:0] FUNCT_BEQ  = 5'd15;
    localparam logic [FUNCT_W-1:0] FUNCT_BNE  = 5'd16;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] RFUNCT_SLL  = 6'h00;
    localparam logic [5:0] RFUNCT_SRL  = 6'h02;
    localparam logic [5:0] RFUNCT_SRA  = 6'h03;
    localparam logic [5:0] RFUNCT_ADD  = 6'h20;
    localparam logic [5:0] RFUNCT_ADDU = 6'h21;
    localparam logic [5:0] RFUNCT_SUB  = 6'h22;
    localparam logic [5:0] RFUNCT_SUBU = 6'h23;
    localparam logic [5:0] RFUNCT_AND  = 6'h24;
    localparam logic [5:0] RFUNCT_OR   = 6'h25;
    localparam logic [5:0] RFUNCT_XOR  = 6'h26;
    localparam logic [5:0] RFUNCT_SLT  = 6'h2A;
    localparam logic [5:0] RFUNCT_SLTU = 6'h2B;

    typedef struct packed {
        logic                 illegal;
        logic [FUNCT_W-1:0]   funct;
        logic                 alu_src;
        logic [IMM_WIDTH-1:0] imm;
        logic [4:0]           rs;
        logic [4:0]           rt;
        logic [4:0]           rd;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
    } dec_t;

    function automatic dec_t dec_bubble();
        dec_t b;
        b = '0;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_alu_ctrl_id_decoder.sv
// Pure combinational instruction decoder: instruction word to ALU control bundle,
// plus flags telling the hazard logic which source registers are really read.
module id_decoder
    import id_ex_alu_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o,
    output logic        reads_rs_o,
    output logic        reads_rt_o
);

    logic [5:0] op_s;
    logic [5:0] fn_s;
    logic [4:0] rs_f_s;
    logic [4:0] rt_f_s;
    logic [4:0] rd_f_s;
    logic [4:0] shamt_s;
    dec_t       d_s;
    logic       rrs_s;
    logic       rrt_s;

    assign op_s    = instr_i[31:26];
    assign rs_f_s  = instr_i[25:21];
    assign rt_f_s  = instr_i[20:16];
    assign rd_f_s  = instr_i[15:11];
    assign shamt_s = instr_i[10:6];
    assign fn_s    = instr_i[5:0];

    // Opcode/funct decode into the control bundle
    always_comb begin
        d_s   = dec_bubble();
        rrs_s = 1'b0;
        rrt_s = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                d_s.rs        = rs_f_s;
                d_s.rt        = rt_f_s;
                d_s.rd        = rd_f_s;
                d_s.reg_write = 1'b1;
                rrs_s         = 1'b1;
                rrt_s         = 1'b1;
                case (fn_s)
                    RFUNCT_ADD:               d_s.funct = FUNCT_ADD;
                    RFUNCT_ADDU:              d_s.funct = FUNCT_ADDU;
                    RFUNCT_SUB, RFUNCT_SUBU:  d_s.funct = FUNCT_SUB;
                    RFUNCT_AND:               d_s.funct = FUNCT_AND;
                    RFUNCT_OR:                d_s.funct = FUNCT_OR;
                    RFUNCT_XOR:               d_s.funct = FUNCT_XOR;
                    RFUNCT_SLT:               d_s.funct = FUNCT_SLT;
                    RFUNCT_SLTU:              d_s.funct = FUNCT_SLTU;
                    RFUNCT_SLL, RFUNCT_SRL, RFUNCT_SRA: begin
                        // Shifts take their only register operand from rt, moved into the rs slot
                        d_s.funct   = (fn_s == RFUNCT_SLL) ? FUNCT_SLL :
                                      (fn_s == RFUNCT_SRL) ? FUNCT_SRL : FUNCT_SRA;
                        d_s.rs      = rt_f_s;
                        d_s.rt      = 5'd0;
                        d_s.alu_src = 1'b1;
                        d_s.imm     = {11'd0, shamt_s};
                        rrt_s       = 1'b0;
                    end
                    default: d_s.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LW: begin
                d_s.rs        = rs_f_s;
                d_s.rt        = rt_f_s;
                d_s.rd        = rt_f_s;
                d_s.imm       = instr_i[15:0];
                d_s.alu_src   = 1'b1;
                d_s.reg_write = 1'b1;
                d_s.mem_read  = (op_s == OP_LW);
                rrs_s         = 1'b1;
                case (op_s)
                    OP_ADDIU: d_s.funct = FUNCT_ADDU;
                    OP_ANDI:  d_s.funct = FUNCT_AND;
                    OP_ORI:   d_s.funct = FUNCT_OR;
                    OP_XORI:  d_s.funct = FUNCT_XOR;
                    OP_SLTI:  d_s.funct = FUNCT_SLT;
                    OP_SLTIU: d_s.funct = FUNCT_SLTU;
                    default:  d_s.funct = FUNCT_ADD;
                endcase
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                d_s.rs        = rs_f_s;
                d_s.rt        = rt_f_s;
                d_s.imm       = instr_i[15:0];
                d_s.alu_src   = (op_s == OP_SW);
                d_s.mem_write = (op_s == OP_SW);
                d_s.funct     = (op_s == OP_BEQ) ? FUNCT_BEQ :
                                (op_s == OP_BNE) ? FUNCT_BNE : FUNCT_ADD;
                rrs_s         = 1'b1;
                rrt_s         = 1'b1;
            end
            default: d_s.illegal = 1'b1;
        endcase

        if (d_s.illegal) begin
            d_s         = dec_bubble();
            d_s.illegal = 1'b1;
            rrs_s       = 1'b0;
            rrt_s       = 1'b0;
        end else if (d_s.rd == 5'd0) begin
            d_s.reg_write = 1'b0;
        end else begin
            d_s.reg_write = d_s.reg_write;
        end
    end

    assign dec_o      = d_s;
    assign reads_rs_o = rrs_s;
    assign reads_rt_o = rrt_s;

endmodule

// File: rtl/id_ex_alu_ctrl.sv
// ID stage and ID/EX pipeline register: decode, load-use hazard stall,
// EX redirect flush and downstream hold.
module id_ex_alu_ctrl
    import id_ex_alu_ctrl_pkg::*;
#(
    parameter int IWIDTH    = 32,
    parameter int PC_WIDTH  = 32,
    parameter int IMM_WIDTH = 16,
    parameter int FUNCT_W   = 5
) (
    input  logic                 d_i_clk,
    input  logic                 d_i_rst_n,
    input  logic                 d_i_valid,
    input  logic [IWIDTH-1:0]    d_i_instr,
    input  logic [PC_WIDTH-1:0]  d_i_pc,
    input  logic                 d_i_flush,
    input  logic                 d_i_ex_hold,
    output logic                 d_o_stall,
    output logic                 d_o_valid,
    output logic [FUNCT_W-1:0]   d_o_funct,
    output logic                 d_o_alu_src,
    output logic [IMM_WIDTH-1:0] d_o_imm,
    output logic [PC_WIDTH-1:0]  d_o_pc,
    output logic [4:0]           d_o_rs,
    output logic [4:0]           d_o_rt,
    output logic [4:0]           d_o_rd,
    output logic                 d_o_reg_write,
    output logic                 d_o_mem_read,
    output logic                 d_o_mem_write,
    output logic                 d_o_illegal
);

    dec_t                dec_s;
    logic                reads_rs_s;
    logic                reads_rt_s;
    logic                hazard_s;

    logic                valid_d, valid_q;
    dec_t                ctrl_d, ctrl_q;
    logic [PC_WIDTH-1:0] pc_d, pc_q;

    id_decoder u_id_decoder (
        .instr_i    (d_i_instr[31:0]),
        .dec_o      (dec_s),
        .reads_rs_o (reads_rs_s),
        .reads_rt_o (reads_rt_s)
    );

    // A load in ID/EX whose destination is read by the instruction now in ID
    assign hazard_s = valid_q & ctrl_q.mem_read & (ctrl_q.rd != 5'd0) & d_i_valid &
                      ((reads_rs_s & (dec_s.rs == ctrl_q.rd)) |
                       (reads_rt_s & (dec_s.rt == ctrl_q.rd)));

    assign d_o_stall = ~d_i_flush & (d_i_ex_hold | hazard_s);

    // Next ID/EX contents: flush > hold > bubble (hazard or no input) > load
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        pc_d    = pc_q;
        if (d_i_flush) begin
            valid_d = 1'b0;
            ctrl_d  = dec_bubble();
            pc_d    = '0;
        end else if (d_i_ex_hold) begin
            valid_d = valid_q;
        end else if (hazard_s || !d_i_valid) begin
            valid_d = 1'b0;
            ctrl_d  = dec_bubble();
            pc_d    = '0;
        end else begin
            valid_d = 1'b1;
            ctrl_d  = dec_s;
            pc_d    = d_i_pc;
        end
    end

    // ID/EX register
    always_ff @(posedge d_i_clk or negedge d_i_rst_n) begin
        if (!d_i_rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= dec_bubble();
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_d;
        end
    end

    assign d_o_valid     = valid_q;
    assign d_o_funct     = ctrl_q.funct;
    assign d_o_alu_src   = ctrl_q.alu_src;
    assign d_o_imm       = ctrl_q.imm;
    assign d_o_pc        = pc_q;
    assign d_o_rs        = ctrl_q.rs;
    assign d_o_rt        = ctrl_q.rt;
    assign d_o_rd        = ctrl_q.rd;
    assign d_o_reg_write = ctrl_q.reg_write;
    assign d_o_mem_read  = ctrl_q.mem_read;
    assign d_o_mem_write = ctrl_q.mem_write;
    assign d_o_illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// Directed-vector bench for id_ex_alu_ctrl with hand-computed expected control words.
module tb_id_ex_alu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        ex_hold;
    logic        stall;
    logic        o_valid;
    logic [4:0]  o_funct;
    logic        o_alu_src;
    logic [15:0] o_imm;
    logic [31:0] o_pc;
    logic [4:0]  o_rs, o_rt, o_rd;
    logic        o_rw, o_mr, o_mw, o_ill;

    int nvec;
    int nerr;

    id_ex_alu_ctrl dut (
        .d_i_clk       (clk),
        .d_i_rst_n     (rst_n),
        .d_i_valid     (valid),
        .d_i_instr     (instr),
        .d_i_pc        (pc),
        .d_i_flush     (flush),
        .d_i_ex_hold   (ex_hold),
        .d_o_stall     (stall),
        .d_o_valid     (o_valid),
        .d_o_funct     (o_funct),
        .d_o_alu_src   (o_alu_src),
        .d_o_imm       (o_imm),
        .d_o_pc        (o_pc),
        .d_o_rs        (o_rs),
        .d_o_rt        (o_rt),
        .d_o_rd        (o_rd),
        .d_o_reg_write (o_rw),
        .d_o_mem_read  (o_mr),
        .d_o_mem_write (o_mw),
        .d_o_illegal   (o_ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed control word: valid funct alu_src imm rs rt rd rw mr mw illegal
    logic [41:0] obs;
    assign obs = {o_valid, o_funct, o_alu_src, o_imm, o_rs, o_rt, o_rd, o_rw, o_mr, o_mw, o_ill};

    function automatic logic [41:0] ev(input logic v, input logic [4:0] f, input logic a,
                                       input logic [15:0] im, input logic [4:0] s,
                                       input logic [4:0] t, input logic [4:0] d,
                                       input logic w, input logic r, input logic m,
                                       input logic il);
        return {v, f, a, im, s, t, d, w, r, m, il};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i);
        valid = v;
        instr = i;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; instr = 32'd0; pc = 32'd0; flush = 1'b0; ex_hold = 1'b0;
        tick();
        tick();
        nvec++;
        if (obs !== 42'd0 || o_pc !== 32'd0) begin
            nerr++; $display("FAIL reset: got %h pc %h want 0", obs, o_pc);
        end
        nvec++;
        if (stall !== 1'b0) begin
            nerr++; $display("FAIL reset_stall: got %b want 0", stall);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        logic [31:0] iv [13];
        logic [41:0] ex [13];
        iv[0]  = 32'h00221820; ex[0]  = ev(1'b1, 5'd0,  1'b0, 16'h0000, 5'd1, 5'd2, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0);
        iv[1]  = 32'h2005FFFC; ex[1]  = ev(1'b1, 5'd0,  1'b1, 16'hFFFC, 5'd0, 5'd5, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0);
        iv[2]  = 32'h000220C0; ex[2]  = ev(1'b1, 5'd7,  1'b1, 16'h0003, 5'd2, 5'd0, 5'd4,  1'b1, 1'b0, 1'b0, 1'b0);
        iv[3]  = 32'h00643822; ex[3]  = ev(1'b1, 5'd1,  1'b0, 16'h0000, 5'd3, 5'd4, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0);
        iv[4]  = 32'h00021903; ex[4]  = ev(1'b1, 5'd9,  1'b1, 16'h0004, 5'd2, 5'd0, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0);
        iv[5]  = 32'h342600FF; ex[5]  = ev(1'b1, 5'd3,  1'b1, 16'h00FF, 5'd1, 5'd6, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0);
        iv[6]  = 32'hAD280004; ex[6]  = ev(1'b1, 5'd0,  1'b1, 16'h0004, 5'd9, 5'd8, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0);
        iv[7]  = 32'h10220008; ex[7]  = ev(1'b1, 5'd15, 1'b0, 16'h0008, 5'd1, 5'd2, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        iv[8]  = 32'h14220008; ex[8]  = ev(1'b1, 5'd16, 1'b0, 16'h0008, 5'd1, 5'd2, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        iv[9]  = 32'hFC000000; ex[9]  = ev(1'b1, 5'd0,  1'b0, 16'h0000, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1);
        iv[10] = 32'h0022183F; ex[10] = ev(1'b1, 5'd0,  1'b0, 16'h0000, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1);
        iv[11] = 32'h00000000; ex[11] = ev(1'b1, 5'd7,  1'b1, 16'h0000, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        iv[12] = 32'h20000005; ex[12] = ev(1'b1, 5'd0,  1'b1, 16'h0005, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 13; k++) begin
            drive(1'b1, iv[k]);
            pc = 32'h1000_0000 + 32'(k * 4);
            tick();
            nvec++;
            if (obs !== ex[k] || o_pc !== 32'h1000_0000 + 32'(k * 4)) begin
                nerr++;
                $display("FAIL decode[%0d] instr %h: got %h pc %h want %h pc %h", k, iv[k], obs, o_pc,
                         ex[k], 32'h1000_0000 + 32'(k * 4));
            end
        end
    endtask

    task automatic test_load_use();
        drive(1'b1, 32'h8D280000);
        tick();
        nvec++;
        if (obs !== ev(1'b1, 5'd0, 1'b1, 16'h0, 5'd9, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0)) begin
            nerr++; $display("FAIL lw_decode: got %h", obs);
        end
        drive(1'b1, 32'h01015020);
        #1;
        nvec++;
        if (stall !== 1'b1) begin
            nerr++; $display("FAIL lu_stall: got %b want 1", stall);
        end
        tick();
        nvec++;
        if (obs !== 42'd0 || stall !== 1'b0) begin
            nerr++; $display("FAIL lu_bubble: got %h stall %b want 0 stall 0", obs, stall);
        end
        tick();
        nvec++;
        if (obs !== ev(1'b1, 5'd0, 1'b0, 16'h0, 5'd8, 5'd1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0)) begin
            nerr++; $display("FAIL lu_issue: got %h", obs);
        end
        // lw into $0 followed by a reader of $0 must not stall
        drive(1'b1, 32'h8D200000);
        tick();
        drive(1'b1, 32'h00001820);
        #1;
        nvec++;
        if (stall !== 1'b0) begin
            nerr++; $display("FAIL lu_r0: got %b want 0", stall);
        end
        // lw followed by an unrelated instruction must not stall
        drive(1'b1, 32'h8D280000);
        tick();
        drive(1'b1, 32'h00221820);
        #1;
        nvec++;
        if (stall !== 1'b0) begin
            nerr++; $display("FAIL lu_unrelated: got %b want 0", stall);
        end
        tick();
    endtask

    task automatic test_flush_hold();
        drive(1'b1, 32'h10220008);
        tick();
        drive(1'b1, 32'h00221820);
        ex_hold = 1'b1;
        #1;
        nvec++;
        if (stall !== 1'b1) begin
            nerr++; $display("FAIL hold_stall: got %b want 1", stall);
        end
        tick();
        nvec++;
        if (obs !== ev(1'b1, 5'd15, 1'b0, 16'h0008, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            nerr++; $display("FAIL hold_keep: got %h", obs);
        end
        flush = 1'b1;
        #1;
        nvec++;
        if (stall !== 1'b0) begin
            nerr++; $display("FAIL flush_stall: got %b want 0", stall);
        end
        tick();
        nvec++;
        if (obs !== 42'd0) begin
            nerr++; $display("FAIL flush_wins: got %h want 0", obs);
        end
        flush = 1'b0; ex_hold = 1'b0;
        drive(1'b0, 32'h00221820);
        tick();
        nvec++;
        if (obs !== 42'd0) begin
            nerr++; $display("FAIL invalid_bubble: got %h want 0", obs);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h8D280000);
        pc = 32'hABCD_0010;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if (obs !== 42'd0 || o_pc !== 32'd0) begin
            nerr++; $display("FAIL reset_mid: got %h pc %h want 0", obs, o_pc);
        end
        #1;
        rst_n = 1'b1;
        drive(1'b1, 32'h00221820);
        pc = 32'h0000_0040;
        tick();
        nvec++;
        if (obs !== ev(1'b1, 5'd0, 1'b0, 16'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0) ||
            o_pc !== 32'h0000_0040) begin
            nerr++; $display("FAIL post_reset_load: got %h pc %h", obs, o_pc);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_decode();
        test_load_use();
        test_flush_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
